// File: rtl/clock_ui_pkg.sv
// Shared constants for the clock UI and the clock datapath.
// Holds the MODE_* / SELECT_* output codes, the state enums built on those
// codes, the per-button event record and the elaboration-time helpers.
package clock_ui_pkg;

    localparam logic [1:0] MODE_CLOCK      = 2'd0;
    localparam logic [1:0] MODE_CLOCK_EDIT = 2'd1;
    localparam logic [1:0] MODE_STOPWATCH  = 2'd2;
    localparam logic [1:0] MODE_ALARM_EDIT = 2'd3;

    localparam logic [1:0] SELECT_NONE = 2'd0;
    localparam logic [1:0] SELECT_HOUR = 2'd1;
    localparam logic [1:0] SELECT_MIN  = 2'd2;
    localparam logic [1:0] SELECT_SEC  = 2'd3;

    typedef enum logic [1:0] {
        ST_CLOCK      = MODE_CLOCK,
        ST_CLOCK_EDIT = MODE_CLOCK_EDIT,
        ST_STOPWATCH  = MODE_STOPWATCH,
        ST_ALARM_EDIT = MODE_ALARM_EDIT
    } mode_state_t;

    typedef enum logic [1:0] {
        SEL_NONE = SELECT_NONE,
        SEL_HOUR = SELECT_HOUR,
        SEL_MIN  = SELECT_MIN,
        SEL_SEC  = SELECT_SEC
    } sel_t;

    // Debounced button: stable level plus one-cycle press pulse.
    typedef struct packed {
        logic level;
        logic press;
    } btn_evt_t;

    // Millisecond interval to clock cycles; never below one cycle so that
    // reload values of N-1 stay non-negative.
    function automatic int unsigned ms_to_cycles(input int unsigned freq_hz,
                                                 input int unsigned ms);
        int unsigned c;
        c = (freq_hz * ms) / 1000;
        return (c == 0) ? 1 : c;
    endfunction

    function automatic mode_state_t mode_next(input mode_state_t m);
        case (m)
            ST_CLOCK:      return ST_CLOCK_EDIT;
            ST_CLOCK_EDIT: return ST_STOPWATCH;
            ST_STOPWATCH:  return ST_ALARM_EDIT;
            default:       return ST_CLOCK;
        endcase
    endfunction

    function automatic sel_t sel_next(input sel_t s);
        case (s)
            SEL_HOUR: return SEL_MIN;
            SEL_MIN:  return SEL_SEC;
            default:  return SEL_HOUR;
        endcase
    endfunction

endpackage

// File: rtl/clock_ui_controller_button_debouncer.sv
// button_debouncer: 2-flop synchronizer, counting debouncer and rising-edge
// detector for one raw push button.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   btn_raw     - raw asynchronous button, active high
//   evt         - debounced level and one-cycle press pulse
// The press pulse is registered and appears N+2 edges after a clean raw
// rising edge, so a consumer registering on it reacts on edge N+3.
module button_debouncer
    import clock_ui_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 20
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     btn_raw,
    output btn_evt_t evt
);

    localparam int unsigned CW = $clog2(DB_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          state_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            // Count consecutive samples that disagree with the accepted
            // state; any agreeing sample restarts the count.
            if (sync2_q != state_q) begin
                if (cnt_q == CW'(DB_CYCLES - 1)) begin
                    state_q <= sync2_q;
                    press_q <= sync2_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign evt = '{level: state_q, press: press_q};

endmodule

// File: rtl/clock_ui_controller.sv
// clock_ui_controller: four-button user interface for a digital clock.
// Ports:
//   clk, global_reset_n              - clock, asynchronous active-low reset
//   btn_mode/select/inc/reset        - raw active-high buttons
//   mode [1:0]                       - MODE_* code
//   select [1:0]                     - SELECT_* code (field being edited)
//   increment                        - edit pulse, or stopwatch run level
//   reset                            - one-cycle stopwatch clear
//   alarm_enable                     - alarm arm level
// All outputs come straight from flops.
module clock_ui_controller
    import clock_ui_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ     = 1000,
    parameter int unsigned DEBOUNCE_MS     = 20,
    parameter int unsigned REPEAT_DELAY_MS = 500,
    parameter int unsigned REPEAT_RATE_MS  = 100,
    parameter int unsigned EDIT_TIMEOUT_S  = 10
) (
    input  logic       clk,
    input  logic       global_reset_n,
    input  logic       btn_mode,
    input  logic       btn_select,
    input  logic       btn_inc,
    input  logic       btn_reset,
    output logic [1:0] mode,
    output logic [1:0] select,
    output logic       increment,
    output logic       reset,
    output logic       alarm_enable
);

    localparam int unsigned DB_CYC   = ms_to_cycles(CLK_FREQ_HZ, DEBOUNCE_MS);
    localparam int unsigned REP_DLY  = ms_to_cycles(CLK_FREQ_HZ, REPEAT_DELAY_MS);
    localparam int unsigned REP_RATE = ms_to_cycles(CLK_FREQ_HZ, REPEAT_RATE_MS);
    localparam int unsigned TO_RAW   = EDIT_TIMEOUT_S * CLK_FREQ_HZ;
    localparam int unsigned TO_CYC   = (TO_RAW == 0) ? 1 : TO_RAW;
    localparam int unsigned REP_MAX  = (REP_DLY > REP_RATE) ? REP_DLY : REP_RATE;
    localparam int unsigned RW       = $clog2(REP_MAX + 1);
    localparam int unsigned TW       = $clog2(TO_CYC + 1);

    btn_evt_t btn_ev [4];

    button_debouncer #(.DB_CYCLES(DB_CYC)) u_db_mode (
        .clk(clk), .rst_n(global_reset_n), .btn_raw(btn_mode),   .evt(btn_ev[0]));
    button_debouncer #(.DB_CYCLES(DB_CYC)) u_db_select (
        .clk(clk), .rst_n(global_reset_n), .btn_raw(btn_select), .evt(btn_ev[1]));
    button_debouncer #(.DB_CYCLES(DB_CYC)) u_db_inc (
        .clk(clk), .rst_n(global_reset_n), .btn_raw(btn_inc),    .evt(btn_ev[2]));
    button_debouncer #(.DB_CYCLES(DB_CYC)) u_db_reset (
        .clk(clk), .rst_n(global_reset_n), .btn_raw(btn_reset),  .evt(btn_ev[3]));

    logic ev_mode, ev_sel, ev_inc, ev_rst, any_ev, inc_held;

    assign ev_mode  = btn_ev[0].press;
    assign ev_sel   = btn_ev[1].press;
    assign ev_inc   = btn_ev[2].press;
    assign ev_rst   = btn_ev[3].press;
    assign any_ev   = ev_mode | ev_sel | ev_inc | ev_rst;
    assign inc_held = btn_ev[2].level;

    mode_state_t   st_q, st_d;
    sel_t          sel_q, sel_d;
    logic          alarm_q, alarm_d;
    logic          run_q, run_d;
    logic          inc_q, inc_d;
    logic          rst_q, rst_d;
    logic          rep_act_q, rep_act_d;
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic [TW-1:0] idle_q, idle_d;

    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            st_q      <= ST_CLOCK;
            sel_q     <= SEL_NONE;
            alarm_q   <= 1'b0;
            run_q     <= 1'b0;
            inc_q     <= 1'b0;
            rst_q     <= 1'b0;
            rep_act_q <= 1'b0;
            rep_cnt_q <= '0;
            idle_q    <= '0;
        end else begin
            st_q      <= st_d;
            sel_q     <= sel_d;
            alarm_q   <= alarm_d;
            run_q     <= run_d;
            inc_q     <= inc_d;
            rst_q     <= rst_d;
            rep_act_q <= rep_act_d;
            rep_cnt_q <= rep_cnt_d;
            idle_q    <= idle_d;
        end
    end

    always_comb begin
        st_d      = st_q;
        sel_d     = sel_q;
        alarm_d   = alarm_q;
        run_d     = run_q;
        inc_d     = 1'b0;
        rst_d     = 1'b0;
        rep_act_d = rep_act_q;
        rep_cnt_d = rep_cnt_q;
        idle_d    = idle_q;

        if (ev_mode) begin
            // Mode press wins; every other event of this cycle is dropped.
            st_d      = mode_next(st_q);
            sel_d     = (st_d == ST_CLOCK_EDIT || st_d == ST_ALARM_EDIT) ? SEL_HOUR : SEL_NONE;
            run_d     = 1'b0;
            rep_act_d = 1'b0;
            idle_d    = '0;
        end else begin
            case (st_q)
                ST_CLOCK: begin
                    if (ev_sel)
                        alarm_d = ~alarm_q;
                end
                ST_STOPWATCH: begin
                    if (ev_rst) begin
                        rst_d = 1'b1;
                        run_d = 1'b0;
                    end else if (ev_inc) begin
                        run_d = ~run_q;
                    end
                end
                default: begin
                    if (ev_sel)
                        sel_d = sel_next(sel_q);

                    // Auto-repeat: first repeat REP_DLY edges after the press,
                    // then every REP_RATE edges while the debounced level holds.
                    if (ev_inc) begin
                        inc_d     = 1'b1;
                        rep_act_d = 1'b1;
                        rep_cnt_d = RW'(REP_DLY - 1);
                    end else if (rep_act_q) begin
                        if (!inc_held) begin
                            rep_act_d = 1'b0;
                        end else if (rep_cnt_q == '0) begin
                            inc_d     = 1'b1;
                            rep_cnt_d = RW'(REP_RATE - 1);
                        end else begin
                            rep_cnt_d = rep_cnt_q - 1'b1;
                        end
                    end

                    if (any_ev) begin
                        idle_d = '0;
                    end else if (idle_q == TW'(TO_CYC - 1)) begin
                        st_d      = ST_CLOCK;
                        sel_d     = SEL_NONE;
                        rep_act_d = 1'b0;
                        inc_d     = 1'b0;
                        idle_d    = '0;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
            endcase
        end

        // In stopwatch the increment output is the run level itself.
        if (st_d == ST_STOPWATCH)
            inc_d = run_d;
    end

    assign mode         = st_q;
    assign select       = sel_q;
    assign increment    = inc_q;
    assign reset        = rst_q;
    assign alarm_enable = alarm_q;

endmodule

// File: doc/clock_ui_controller.md
CLOCK_UI_CONTROLLER -- requirements
Module: clock_ui_controller

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 1000, clk frequency in Hz (>=1000).
REQ-002 SHALL have parameter DEBOUNCE_MS, default 20, button stable time required before acceptance.
REQ-003 SHALL have parameters REPEAT_DELAY_MS and REPEAT_RATE_MS, defaults 500 and 100, increment auto-repeat timing.
REQ-004 SHALL have parameter EDIT_TIMEOUT_S, default 10, idle time before an edit mode is abandoned.
REQ-005 SHALL have ports: clk  in  1  single clock, rising edge; global_reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: btn_mode, btn_select, btn_inc, btn_reset  in  1 each  raw, asynchronous, active-high buttons.
REQ-007 SHALL have ports: mode  out  2  MODE_* code; select  out  2  SELECT_* code.
REQ-008 SHALL have ports: increment  out  1  edit pulse or stopwatch run level; reset  out  1  stopwatch-clear pulse; alarm_enable  out  1  alarm arm level.

Function
REQ-009 Each button SHALL pass a 2-flop synchronizer, then a debouncer that updates its state only after N = CLK_FREQ_HZ*DEBOUNCE_MS/1000 consecutive equal samples.
REQ-010 Press event SHALL be a one-cycle pulse exactly N+3 cycles after a raw rising edge held stable; releases produce no event.
REQ-011 Mode FSM SHALL advance on a btn_mode press: CLOCK -> CLOCK_EDIT -> STOPWATCH -> ALARM_EDIT -> CLOCK.
REQ-012 On entering CLOCK_EDIT or ALARM_EDIT, select SHALL be SELECT_HOUR; each btn_select press SHALL cycle HOUR -> MIN -> SEC -> HOUR.
REQ-013 In CLOCK and STOPWATCH, select SHALL be SELECT_NONE.
REQ-014 In edit modes, a btn_inc press SHALL give a one-cycle increment pulse in the event cycle; while held, a pulse every REPEAT_RATE cycles SHALL follow, the first REPEAT_DELAY cycles after the event; release stops repeats immediately.
REQ-015 In STOPWATCH, each btn_inc press SHALL toggle a run latch, and increment SHALL equal the latch; leaving STOPWATCH SHALL clear the latch.
REQ-016 In STOPWATCH, a btn_reset press SHALL give reset high for one cycle and clear the run latch in the same cycle; outside STOPWATCH, btn_reset SHALL be ignored and reset stays 0.
REQ-017 In CLOCK, a btn_select press SHALL toggle alarm_enable; alarm_enable SHALL persist across all modes.
REQ-018 In CLOCK, increment SHALL be 0.
REQ-019 In edit modes, an idle timer SHALL restart on any press event; at EDIT_TIMEOUT_S*CLK_FREQ_HZ cycles without one, mode SHALL return to CLOCK and select to SELECT_NONE.
REQ-020 Simultaneous press events SHALL be resolved btn_mode first; the other events of that cycle SHALL be discarded.
REQ-021 All counters SHALL saturate or reload; none SHALL wrap into a spurious event.
REQ-022 All outputs SHALL be registered.

Reset
REQ-023 Asserting global_reset_n low SHALL asynchronously force: mode=CLOCK, select=SELECT_NONE, increment=0, reset=0, alarm_enable=0, run latch=0, all debouncers released, all timers cleared.
REQ-024 Release SHALL take effect on the next clk edge.
REQ-025 A button held through release SHALL need a full debounce before its press event.

Structure
REQ-026 MODE_* and SELECT_* codes SHALL come from the shared constants include already used by the clock datapath; no local redefinition.
REQ-027 Millisecond-to-cycle conversions SHALL be computed from parameters at elaboration.
REQ-028 Synchronizer plus debouncer plus edge detect SHALL be one sub-module, button_debouncer, instantiated four times.

Verification
Bench parameters: CLK_FREQ_HZ=1000, DEBOUNCE_MS=4, REPEAT_DELAY_MS=20, REPEAT_RATE_MS=5, EDIT_TIMEOUT_S=1.
REQ-029 Bounce test: btn_mode toggles every 2 cycles for 10 cycles, then holds 1 -> mode stays CLOCK during bounce; mode becomes CLOCK_EDIT 7 cycles after stable; select=HOUR.
REQ-030 Mode cycling: 4 clean btn_mode presses -> mode CLOCK_EDIT, STOPWATCH, ALARM_EDIT, CLOCK; select NONE, HOUR, NONE, HOUR, NONE per mode.
REQ-031 Auto-repeat: in CLOCK_EDIT, btn_inc held 40 cycles past its event -> pulses at event+0, +20, +25, +30, +35, +40; none after release.
REQ-032 Stopwatch: press btn_inc -> increment=1; press btn_reset -> reset pulse of 1 cycle and increment=0; btn_mode press while running -> increment=0.
REQ-033 Timeout and priority: enter ALARM_EDIT, idle 1000 cycles -> mode=CLOCK; btn_mode and btn_select pressed in the same cycle in CLOCK -> mode=CLOCK_EDIT, alarm_enable unchanged.
REQ-034 Reset mid-operation: global_reset_n low during auto-repeat -> all outputs at REQ-023 values within the same cycle.
